nios2_debug_slave_cmd_queue: RTL and testbench

// - System-clock side of the Nios II JTAG debug slave, second generation.
// - Takes update pulses, IR value and DR shift contents from the TCK-side logic and

---
 rtl/nios2_dbg_pkg.sv | 22 ++
 rtl/nios2_dbg_cmd_fifo.sv | 50 +++++
 rtl/nios2_debug_slave_cmd_queue.sv | 113 +++++++++++
 tb/tb_nios2_debug_slave_cmd_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared types and action-code constants for the Nios II debug slave command path.
// Default widths here match the classic 2-bit IR / 38-bit DR debug slave.
package nios2_dbg_pkg;

    localparam int DBG_IR_WIDTH = 2;
    localparam int DBG_DR_WIDTH = 38;
    localparam int ACT_W        = DBG_IR_WIDTH + 2;

    // Action code = {ir, dr[DR_WIDTH-3], dr[DR_WIDTH-4]}
    localparam logic [ACT_W-1:0] OCIMEM_A  = 4'h1;
    localparam logic [ACT_W-1:0] OCIMEM_B  = 4'h2;
    localparam logic [ACT_W-1:0] BREAK_A   = 4'h8;
    localparam logic [ACT_W-1:0] BREAK_B   = 4'h9;
    localparam logic [ACT_W-1:0] BREAK_C   = 4'hA;
    localparam logic [ACT_W-1:0] TRACECTRL = 4'hC;

    typedef struct packed {
        logic [DBG_IR_WIDTH-1:0] ir;
        logic [DBG_DR_WIDTH-1:0] dr;
    } dbg_cmd_t;

endpackage

// File: rtl/nios2_dbg_cmd_fifo.sv
// Synchronous command FIFO with a registered level; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module nios2_dbg_cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    // Storage carries no reset; the level alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/nios2_debug_slave_cmd_queue.sv
// System-clock side of the JTAG debug slave: resynchronises TCK-side updates,
// queues each DR update and issues it to the core as a one-hot strobe.
module nios2_debug_slave_cmd_queue
    import nios2_dbg_pkg::*;
#(
    parameter int IR_WIDTH    = DBG_IR_WIDTH,
    parameter int DR_WIDTH    = DBG_DR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    localparam int NUM_ACT    = 2 ** (IR_WIDTH + 2),
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vs_uir,
    input  logic                vs_udr,
    input  logic                jtag_state_rti,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [DR_WIDTH-1:0] sr,
    input  logic                core_ready,
    input  logic                overflow_clr,
    output logic [DR_WIDTH-1:0] jdo,
    output logic [NUM_ACT-1:0]  take_action,
    output logic                cmd_pending,
    output logic [LW-1:0]       queue_level,
    output logic                overflow,
    output logic                st_ready_test_idle
);

    localparam int CW     = IR_WIDTH + DR_WIDTH;
    localparam int CODE_W = IR_WIDTH + 2;

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] rti_sync;
    logic                   uir_prev;
    logic                   udr_prev;
    logic                   uir_rise;
    logic                   udr_rise;
    logic [IR_WIDTH-1:0]    ir_reg;

    logic [CW-1:0]          head;
    logic [IR_WIDTH-1:0]    head_ir;
    logic [DR_WIDTH-1:0]    head_dr;
    logic [CODE_W-1:0]      code;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop_ok;
    logic                   drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            rti_sync <= '0;
            uir_prev <= 1'b0;
            udr_prev <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            rti_sync <= {rti_sync[SYNC_STAGES-2:0], jtag_state_rti};
            uir_prev <= uir_sync[SYNC_STAGES-1];
            udr_prev <= udr_sync[SYNC_STAGES-1];
        end
    end

    assign uir_rise           = uir_sync[SYNC_STAGES-1] && !uir_prev;
    assign udr_rise           = udr_sync[SYNC_STAGES-1] && !udr_prev;
    assign st_ready_test_idle = rti_sync[SYNC_STAGES-1];

    // A DR push in the same cycle as an IR update still sees the old ir_reg.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      ir_reg <= '0;
        else if (uir_rise) ir_reg <= ir_in;
    end

    nios2_dbg_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (udr_rise),
        .pop     (core_ready),
        .wdata   ({ir_reg, sr}),
        .rdata   (head),
        .level   (queue_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign cmd_pending = !fifo_empty;
    assign pop_ok      = core_ready && !fifo_empty;
    assign drop        = udr_rise && fifo_full && !pop_ok;
    assign head_ir     = head[CW-1:DR_WIDTH];
    assign head_dr     = head[DR_WIDTH-1:0];
    assign code        = {head_ir, head_dr[DR_WIDTH-3], head_dr[DR_WIDTH-4]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo         <= '0;
            take_action <= '0;
            overflow    <= 1'b0;
        end else begin
            take_action <= pop_ok ? ({{(NUM_ACT-1){1'b0}}, 1'b1} << code) : '0;
            if (pop_ok) jdo <= head_dr;
            // A fresh drop outranks a clear in the same cycle.
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nios2_debug_slave_cmd_queue.sv
// Self-checking bench for the debug slave command queue: table-driven action
// codes, back-pressure, overflow, full push/pop, async reset and sync checks.
module tb_nios2_debug_slave_cmd_queue;

    localparam int IR_W   = 2;
    localparam int DR_W   = 38;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 4;
    localparam int NACT   = 16;
    localparam int LW     = 3;
    localparam int W      = NACT + DR_W;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic            jtag_state_rti = 1'b0;
    logic [IR_W-1:0] ir_in = '0;
    logic [DR_W-1:0] sr = '0;
    logic            core_ready = 1'b0;
    logic            overflow_clr = 1'b0;
    logic [DR_W-1:0] jdo;
    logic [NACT-1:0] take_action;
    logic            cmd_pending;
    logic [LW-1:0]   queue_level;
    logic            overflow;
    logic            st_ready_test_idle;

    nios2_debug_slave_cmd_queue #(
        .IR_WIDTH    (IR_W),
        .DR_WIDTH    (DR_W),
        .SYNC_STAGES (SYNC),
        .DEPTH       (DEPTH)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .vs_uir             (vs_uir),
        .vs_udr             (vs_udr),
        .jtag_state_rti     (jtag_state_rti),
        .ir_in              (ir_in),
        .sr                 (sr),
        .core_ready         (core_ready),
        .overflow_clr       (overflow_clr),
        .jdo                (jdo),
        .take_action        (take_action),
        .cmd_pending        (cmd_pending),
        .queue_level        (queue_level),
        .overflow           (overflow),
        .st_ready_test_idle (st_ready_test_idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_strobes = 0;
    int last_strobe_cyc = 0;
    int drive_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [IR_W-1:0] cur_ir = '0;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [1:0]      sel;
        logic [NACT-1:0] exp_ta;
    } vec_t;

    vec_t vecs [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected command.
    always @(negedge clk) begin
        if (reset_n && take_action != '0) begin
            logic [W-1:0] e;
            n_strobes++;
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'(take_action), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_take_action", 64'(take_action), 64'(e[W-1:DR_W]));
                check("strobe_jdo", 64'(jdo), 64'(e[DR_W-1:0]));
            end
        end
    end

    function automatic logic [DR_W-1:0] make_sr(input logic [1:0] sel);
        logic [63:0] rnd;
        rnd = {$urandom, $urandom};
        return {2'b01, sel, rnd[DR_W-5:0]};
    endfunction

    task automatic uir_pulse(input logic [IR_W-1:0] ir);
        @(negedge clk);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (2) @(negedge clk);
        vs_uir = 1'b0;
        repeat (4) @(negedge clk);
        cur_ir = ir;
    endtask

    // Queues an expectation only when the command is predicted to be issued.
    task automatic udr_pulse(input logic [DR_W-1:0] val, input logic [NACT-1:0] exp_ta,
                             input bit expect_issue);
        @(negedge clk);
        sr        = val;
        vs_udr    = 1'b1;
        drive_cyc = cyc;
        if (expect_issue) exp_q.push_back({exp_ta, val});
        repeat (2) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [NACT-1:0] model_ta(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] d);
        logic [3:0] c;
        c = {ir, d[DR_W-3], d[DR_W-4]};
        return NACT'(1) << c;
    endfunction

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (n_strobes < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_strobes < target) check("strobe_timeout", 64'(n_strobes), 64'(target));
    endtask

    task automatic queue_cmds(input int n, input int n_issue);
        logic [DR_W-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = make_sr(2'($urandom_range(0, 3)));
            udr_pulse(v, model_ta(cur_ir, v), i < n_issue);
        end
    endtask

    initial begin
        int base;
        int r;
        logic [DR_W-1:0] v;

        vecs[0] = '{ir: 2'd0, sel: 2'b01, exp_ta: 16'h0002};
        vecs[1] = '{ir: 2'd0, sel: 2'b10, exp_ta: 16'h0004};
        vecs[2] = '{ir: 2'd2, sel: 2'b00, exp_ta: 16'h0100};
        vecs[3] = '{ir: 2'd2, sel: 2'b01, exp_ta: 16'h0200};
        vecs[4] = '{ir: 2'd3, sel: 2'b11, exp_ta: 16'h8000};
        vecs[5] = '{ir: 2'd1, sel: 2'b10, exp_ta: 16'h0040};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_jdo", 64'(jdo), 64'd0);
        check("reset_take_action", 64'(take_action), 64'd0);
        check("reset_pending", 64'(cmd_pending), 64'd0);
        check("reset_level", 64'(queue_level), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_rti", 64'(st_ready_test_idle), 64'd0);
        reset_n    = 1'b1;
        core_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Single command: latency and single-cycle strobe
        uir_pulse(2'd0);
        base = n_strobes;
        udr_pulse(make_sr(2'b01), 16'h0002, 1'b1);
        wait_strobes(base + 1, 50);
        check("single_latency", 64'(last_strobe_cyc - drive_cyc), 64'(SYNC + 2));
        repeat (5) @(negedge clk);
        check("single_strobe_count", 64'(n_strobes - base), 64'd1);
        check("single_level", 64'(queue_level), 64'd0);

        // Table of action codes
        for (int i = 0; i < 6; i++) begin
            uir_pulse(vecs[i].ir);
            base = n_strobes;
            udr_pulse(make_sr(vecs[i].sel), vecs[i].exp_ta, 1'b1);
            wait_strobes(base + 1, 50);
            check("table_pending", 64'(cmd_pending), 64'd0);
        end

        // Back-pressure: three queued, then drained on consecutive cycles
        uir_pulse(2'd2);
        core_ready = 1'b0;
        base = n_strobes;
        queue_cmds(3, 3);
        check("bp_level", 64'(queue_level), 64'd3);
        check("bp_pending", 64'(cmd_pending), 64'd1);
        check("bp_no_strobe", 64'(n_strobes - base), 64'd0);
        r = cyc;
        core_ready = 1'b1;
        wait_strobes(base + 3, 20);
        check("bp_consecutive", 64'(last_strobe_cyc - r), 64'd3);
        check("bp_level_drained", 64'(queue_level), 64'd0);

        // Overflow: fifth command dropped, flag sticky until cleared
        core_ready = 1'b0;
        base = n_strobes;
        queue_cmds(5, 4);
        check("ovf_level", 64'(queue_level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        core_ready = 1'b1;
        wait_strobes(base + 4, 20);
        repeat (5) @(negedge clk);
        check("ovf_issued", 64'(n_strobes - base), 64'd4);
        check("ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full queue with push and pop in the same cycle
        core_ready = 1'b0;
        base = n_strobes;
        queue_cmds(4, 4);
        check("full_level", 64'(queue_level), 64'd4);
        v = make_sr(2'b11);
        @(negedge clk);
        sr     = v;
        vs_udr = 1'b1;
        exp_q.push_back({model_ta(cur_ir, v), v});
        @(negedge clk);
        @(negedge clk);
        core_ready = 1'b1;
        vs_udr     = 1'b0;
        @(negedge clk);
        core_ready = 1'b0;
        check("full_pp_level", 64'(queue_level), 64'd4);
        check("full_pp_overflow", 64'(overflow), 64'd0);
        core_ready = 1'b1;
        wait_strobes(base + 5, 30);
        check("full_pp_issued", 64'(n_strobes - base), 64'd5);

        // Async reset with two commands queued
        core_ready = 1'b0;
        queue_cmds(2, 2);
        check("rst_pre_level", 64'(queue_level), 64'd2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_level", 64'(queue_level), 64'd0);
        check("rst_async_pending", 64'(cmd_pending), 64'd0);
        check("rst_async_jdo", 64'(jdo), 64'd0);
        check("rst_async_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        cur_ir = '0;
        @(negedge clk);
        reset_n    = 1'b1;
        core_ready = 1'b1;
        base = n_strobes;
        repeat (10) @(negedge clk);
        check("rst_no_strobe", 64'(n_strobes - base), 64'd0);

        // Held-high vs_udr pushes once
        core_ready = 1'b0;
        v = make_sr(2'b10);
        @(negedge clk);
        sr     = v;
        vs_udr = 1'b1;
        exp_q.push_back({model_ta(cur_ir, v), v});
        repeat (20) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        check("held_udr_level", 64'(queue_level), 64'd1);
        core_ready = 1'b1;
        wait_strobes(base + 1, 20);

        // rti synchroniser depth
        @(negedge clk);
        jtag_state_rti = 1'b1;
        @(posedge clk);
        #1 check("rti_stage1", 64'(st_ready_test_idle), 64'd0);
        @(posedge clk);
        #1 check("rti_stage2", 64'(st_ready_test_idle), 64'd1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
